// File: rtl/seg_capture.sv
// Captures a multiplexed, active-low 7-segment display scan into a 4-digit BCD frame.
// A digit is accepted once its anode/segment pattern has been stable for STABLE_CYC samples.
module seg_capture #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic [3:0]  digit_err,
    output logic        stale
);

    localparam logic [7:0]  STABLE_LIM  = 8'(STABLE_CYC);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic [3:0]  r_an_prev;
    logic [6:0]  r_seg_prev;

    logic [7:0]  r_stab_cnt;
    logic [7:0]  w_stab_cnt_nxt;

    logic        w_onehot;
    logic [1:0]  w_idx;
    logic        w_same;
    logic [3:0]  w_val;
    logic        w_illegal;
    logic        w_capture;

    logic [3:0]  r_mask;
    logic [3:0]  w_mask_nxt;
    logic        w_load;
    logic [3:0]  r_shadow [4];
    logic [3:0]  r_shadow_err;

    logic [15:0] r_digits;
    logic [3:0]  r_digit_err;
    logic        r_frame_valid;
    logic [15:0] r_tmo_cnt;

    // Input registers; the previous copy lets stability be judged on registered samples only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an       <= 4'b1111;
            r_seg      <= 7'b1111111;
            r_an_prev  <= 4'b1111;
            r_seg_prev <= 7'b1111111;
        end else begin
            r_an       <= an;
            r_seg      <= seg;
            r_an_prev  <= r_an;
            r_seg_prev <= r_seg;
        end
    end

    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (r_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    assign w_same = ({r_an, r_seg} == {r_an_prev, r_seg_prev});

    always_comb begin
        w_val     = 4'hF;
        w_illegal = 1'b0;
        case (r_seg)
            7'b0000001: w_val = 4'd0;
            7'b1001111: w_val = 4'd1;
            7'b0010010: w_val = 4'd2;
            7'b0000110: w_val = 4'd3;
            7'b1001100: w_val = 4'd4;
            7'b0100100: w_val = 4'd5;
            7'b0100000: w_val = 4'd6;
            7'b0001111: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0000100: w_val = 4'd9;
            default:    w_illegal = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and stability count
    always_comb begin
        w_state_nxt    = r_state;
        w_stab_cnt_nxt = r_stab_cnt;
        case (r_state)
            StIdle: begin
                if (w_onehot) begin
                    w_state_nxt    = StSettle;
                    w_stab_cnt_nxt = 8'd1;
                end else begin
                    w_stab_cnt_nxt = 8'd0;
                end
            end
            StSettle: begin
                if (!w_onehot) begin
                    w_state_nxt    = StIdle;
                    w_stab_cnt_nxt = 8'd0;
                end else if (w_same) begin
                    w_stab_cnt_nxt = r_stab_cnt + 8'd1;
                end else begin
                    w_stab_cnt_nxt = 8'd1;
                end
            end
            StHeld: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_state_nxt    = StSettle;
                        w_stab_cnt_nxt = 8'd1;
                    end else begin
                        w_state_nxt    = StIdle;
                        w_stab_cnt_nxt = 8'd0;
                    end
                end
            end
            default: begin
                w_state_nxt    = StIdle;
                w_stab_cnt_nxt = 8'd0;
            end
        endcase
        // Reaching the limit (even straight from a fresh load when STABLE_CYC is 1) holds the digit.
        if (w_state_nxt == StSettle && w_stab_cnt_nxt == STABLE_LIM) begin
            w_state_nxt = StHeld;
        end
    end

    // FSM: outputs
    always_comb begin
        w_capture = (w_state_nxt == StHeld) && ((r_state != StHeld) || !w_same);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab_cnt <= 8'd0;
        end else begin
            r_stab_cnt <= w_stab_cnt_nxt;
        end
    end

    assign w_load = (r_mask == 4'b1111);

    // Clear-then-set so a capture coinciding with the frame load is kept for the next frame.
    always_comb begin
        w_mask_nxt = w_load ? 4'b0000 : r_mask;
        if (w_capture) begin
            w_mask_nxt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask       <= 4'b0000;
            r_shadow_err <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 4'h0;
            end
        end else begin
            r_mask <= w_mask_nxt;
            if (w_capture) begin
                r_shadow[w_idx]     <= w_val;
                r_shadow_err[w_idx] <= w_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits      <= 16'h0000;
            r_digit_err   <= 4'b0000;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_load;
            if (w_load) begin
                r_digits    <= {r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
                r_digit_err <= r_shadow_err;
            end
        end
    end

    // Cleared at the end of the frame_valid cycle, so stale drops on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_frame_valid) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_tmo_cnt != TIMEOUT_LIM) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign digits      = r_digits;
    assign digit_err   = r_digit_err;
    assign frame_valid = r_frame_valid;
    assign stale       = (r_tmo_cnt == TIMEOUT_LIM);

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scan scenarios plus random scans, all checked each cycle
// against a run-length reference model of the sampled display.
module tb_seg_capture;

    localparam int unsigned S  = 4;
    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        frame_valid;
    logic [3:0]  digit_err;
    logic        stale;

    seg_capture #(
        .STABLE_CYC (S),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    int          n_checks = 0;
    int          n_err    = 0;
    int          fv_seen  = 0;

    logic [10:0] hist [$];
    logic [3:0]  m_sh [4];
    logic [3:0]  m_sh_err;
    logic [3:0]  m_mask;
    logic [15:0] m_digits;
    logic [3:0]  m_err;
    logic        m_fv;
    int unsigned m_tcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sel(input int d);
        return ~(4'b0001 << d);
    endfunction

    // {illegal, value}
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (glyph[i] == s) return {1'b0, 4'(i)};
        end
        return 5'h1F;
    endfunction

    // Length of the run of identical one-hot samples ending at the newest sample.
    function automatic int run_len();
        logic [10:0] v;
        int          l;
        bit          done;
        if (hist.size() == 0) return 0;
        v = hist[hist.size() - 1];
        if ($countones(~v[10:7]) != 1) return 0;
        l    = 0;
        done = 1'b0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (!done && hist[i] == v && l <= int'(S)) l++;
            else done = 1'b1;
        end
        return l;
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
        m_sh_err = 4'h0;
        m_mask   = 4'h0;
        m_digits = 16'h0;
        m_err    = 4'h0;
        m_fv     = 1'b0;
        m_tcnt   = 0;
    endtask

    // Advance the model across one clock edge; the newest history entry is the sample
    // that the design examines at this edge.
    task automatic model_step();
        logic        load;
        logic        old_fv;
        logic [3:0]  new_mask;
        logic [10:0] v;
        logic [4:0]  dec;
        int          idx;
        load   = (m_mask == 4'hF);
        old_fv = m_fv;
        m_fv   = load;
        if (load) begin
            m_digits = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_err    = m_sh_err;
        end
        if (old_fv) m_tcnt = 0;
        else if (m_tcnt < TO) m_tcnt++;
        new_mask = load ? 4'h0 : m_mask;
        if (run_len() == int'(S)) begin
            v   = hist[hist.size() - 1];
            idx = 0;
            for (int d = 0; d < 4; d++) if (!v[7 + d]) idx = d;
            dec           = ref_decode(v[6:0]);
            m_sh[idx]     = dec[3:0];
            m_sh_err[idx] = dec[4];
            new_mask[idx] = 1'b1;
        end
        m_mask = new_mask;
    endtask

    task automatic tick(input logic [3:0] a, input logic [6:0] s);
        model_step();
        hist.push_back({a, s});
        if (hist.size() > 16) void'(hist.pop_front());
        an  = a;
        seg = s;
        @(posedge clk);
        #1;
        chk("digits", 32'(digits), 32'(m_digits));
        chk("digit_err", 32'(digit_err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("stale", 32'(stale), 32'(m_tcnt == TO));
        if (frame_valid === 1'b1) fv_seen++;
    endtask

    task automatic hold(input int d, input int g, input int n);
        repeat (n) tick(sel(d), glyph[g]);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'hF, 7'h7F);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_digit_err", 32'(digit_err), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int         len;

        rst_n = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        model_clear();
        #2;
        do_reset();

        // No scanning: stale rises exactly TIMEOUT cycles after release.
        idle(99);
        chk("stale_before_timeout", 32'(stale), 32'h0);
        idle(1);
        chk("stale_at_timeout", 32'(stale), 32'h1);

        // Clean scan of 1,2,3,4.
        fv_seen = 0;
        hold(3, 1, 8);
        hold(2, 2, 8);
        hold(1, 3, 8);
        hold(0, 4, 8);
        idle(3);
        chk("frame_1234", 32'(digits), 32'h1234);
        chk("err_1234", 32'(digit_err), 32'h0);
        chk("fv_count_1234", 32'(fv_seen), 32'd1);
        chk("stale_after_frame", 32'(stale), 32'h0);

        // Digit 2 too short, later held long enough.
        fv_seen = 0;
        hold(3, 1, 8);
        hold(2, 2, 3);
        hold(1, 3, 8);
        hold(0, 4, 8);
        idle(4);
        chk("fv_count_short", 32'(fv_seen), 32'd0);
        hold(2, 7, 5);
        idle(3);
        chk("fv_count_late", 32'(fv_seen), 32'd1);
        chk("frame_1734", 32'(digits), 32'h1734);

        // Illegal glyph on digit 0.
        fv_seen = 0;
        hold(3, 5, 8);
        hold(2, 5, 8);
        hold(1, 5, 8);
        repeat (8) tick(sel(0), 7'b1111110);
        idle(3);
        chk("frame_555F", 32'(digits), 32'h555F);
        chk("err_555F", 32'(digit_err), 32'h1);
        chk("fv_count_555F", 32'(fv_seen), 32'd1);

        // Two anodes on: nothing captured.
        fv_seen = 0;
        repeat (20) tick(4'b0011, glyph[8]);
        chk("fv_count_multi_an", 32'(fv_seen), 32'd0);
        chk("digits_multi_an", 32'(digits), 32'h555F);

        // Recapture of digit 0 overwrites its slot.
        fv_seen = 0;
        hold(0, 1, 6);
        hold(0, 2, 6);
        hold(1, 3, 6);
        hold(2, 3, 6);
        hold(3, 3, 6);
        idle(3);
        chk("frame_3332", 32'(digits), 32'h3332);
        chk("fv_count_3332", 32'(fv_seen), 32'd1);

        // Reset mid-frame discards the partial frame.
        hold(3, 9, 6);
        hold(2, 8, 6);
        hold(1, 7, 6);
        idle(1);
        do_reset();
        fv_seen = 0;
        hold(3, 9, 6);
        hold(2, 8, 6);
        hold(1, 7, 6);
        hold(0, 6, 6);
        idle(3);
        chk("frame_9876", 32'(digits), 32'h9876);
        chk("fv_count_9876", 32'(fv_seen), 32'd1);

        // Random scanning, including glitchy anodes and illegal glyphs.
        for (int k = 0; k < 80; k++) begin
            ra  = ($urandom_range(0, 3) != 0) ? sel(int'($urandom_range(0, 3))) : 4'($urandom);
            rs  = ($urandom_range(0, 4) != 0) ? glyph[$urandom_range(0, 9)] : 7'($urandom);
            len = int'($urandom_range(1, 8));
            repeat (len) tick(ra, rs);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, meaning consecutive identical sampled cycles needed to accept a digit (range 1..255).
REQ-002 Parameter TIMEOUT, default 65535, meaning cycles without a completed frame before stale asserts (16-bit counter).
REQ-003 The clock port shall be clk, input, 1 bit; single clock domain, all state updates on the rising edge.
REQ-004 The reset port shall be rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 an, input, 4 bits, active-low anode enables; an[0] is digit 0 (rightmost), an[3] is digit 3.
REQ-006 seg, input, 7 bits, active-low segments a..g at bits 6..0, in the team's 7-segment encoding ("0"=0000001 ... "9"=0000100).
REQ-007 digits, output, 16 bits, captured BCD frame; digit n at bits [4n+3:4n].
REQ-008 frame_valid, output, 1 bit, single-cycle pulse when digits updates.
REQ-009 digit_err, output, 4 bits, per-digit flag: the frame's pattern for that digit was not a legal glyph.
REQ-010 stale, output, 1 bit, level: no frame completed within TIMEOUT cycles.

Function
REQ-011 an and seg shall be registered once on entry; all decode uses the registered copies (1-cycle input latency).
REQ-012 Decode shall be exact match against the ten legal patterns: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-013 Any other seg pattern shall decode to 4'hF with an illegal flag; it never decodes to 0.
REQ-014 FSM states: IDLE, SETTLE, HELD.
REQ-015 IDLE: registered an not one-hot-low (4'b1111 or two+ zeros); stability counter held at 0; no capture.
REQ-016 IDLE->SETTLE when registered an becomes one-hot-low; counter loads 1.
REQ-017 SETTLE: counter increments each cycle the registered {an,seg} equals the previous cycle; any change reloads counter to 1 (new one-hot an) or goes IDLE (non-one-hot an).
REQ-018 SETTLE->HELD on the cycle the counter reaches STABLE_CYC; that cycle the decoded value and illegal flag are written to the shadow slot for the active digit and its capture-mask bit set.
REQ-019 HELD: no further capture until {an,seg} changes; change -> SETTLE (one-hot an) or IDLE (otherwise).
REQ-020 Recapturing a digit already in the mask shall overwrite its shadow slot; the mask bit stays set.
REQ-021 When the capture mask becomes 4'b1111, on the next cycle digits and digit_err shall load from the shadow slots together, frame_valid pulses high for exactly one cycle, and the mask clears.
REQ-022 A capture on the same cycle the mask clears shall set the new mask bit (clear then set); no capture is lost.
REQ-023 digits and digit_err shall hold between frames; partial frames never reach the outputs.
REQ-024 Timeout counter shall reset to 0 on each frame_valid, otherwise increment saturating at TIMEOUT; stale = (counter == TIMEOUT).
REQ-025 stale shall deassert on the cycle after frame_valid.

Reset
REQ-026 With rst_n low, asynchronously: FSM=IDLE, stability counter=0, capture mask=0, shadow slots=0, digits=16'h0000, digit_err=4'b0000, frame_valid=0, stale=0, timeout counter=0, input registers an=4'b1111, seg=7'b1111111.
REQ-027 Reset asserted mid-frame shall discard the partial frame; after release, capture restarts from an empty mask.
REQ-028 Reset release is synchronous to clk by the integrating design; no reset-release behaviour beyond REQ-026 is required.

Verification
REQ-029 Scan 1,2,3,4 on digits 3..0, each held 8 cycles (STABLE_CYC=4) -> one frame_valid pulse, digits=16'h1234, digit_err=4'b0000.
REQ-030 Digit 2 held only 3 cycles then digit 1 -> no capture for digit 2; frame_valid only after digit 2 later held >=4 cycles.
REQ-031 Digit 0 driven 7'b1111110 for 8 cycles, others legal "5" -> digits=16'h555F, digit_err=4'b0001.
REQ-032 an=4'b0011 (two digits on) for 20 cycles -> FSM stays IDLE, no mask change, no frame_valid.
REQ-033 TIMEOUT=100, no scan -> stale high at cycle 100 after reset release; one valid frame -> stale low next cycle.
REQ-034 rst_n pulsed low after 3 of 4 digits captured -> outputs at reset values immediately; next full scan of 9,8,7,6 -> digits=16'h9876 with exactly one frame_valid.
